trivium_ks_gen: RTL and testbench

Parametrised Trivium keystream generator, successor of the fixed 8-bit ENCRIPT datapath.
- Loads an 80-bit key and 80-bit IV and runs a configurable warm-up.
- Streams W keystream bits per cycle over a valid/ready handshake; the downstream XOR/encrypt stage consumes them.
- A new start restarts the generator at any time.

---
 rtl/trivium_ks_gen.sv | 160 ++++++++++++++++
 tb/tb_trivium_ks_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_ks_gen.sv
// ---------------------------------------------------------------------------
// trivium_ks_gen
//
// Trivium keystream generator. It takes an 80-bit key and an 80-bit IV,
// runs a warm-up of INIT_ROUNDS steps, and then streams W keystream bits per
// clock over a valid/ready handshake. A start pulse reloads the generator at
// any time.
//
// Parameters
//   W            keystream bits (Trivium steps) per clock: 1,2,4,8,16,32,64
//   INIT_ROUNDS  warm-up steps before output; a multiple of W; 0 allowed
//   CNT_W        width of the accepted-word counter
//
// Ports
//   clk       in   clock, all logic on the rising edge
//   reset     in   synchronous active-low reset
//   start     in   load key/iv and begin warm-up (sampled every cycle)
//   key       in   80-bit key, key[i] = K(i+1)
//   iv        in   80-bit IV,  iv[i]  = IV(i+1)
//   busy      out  high while warming up
//   ks_data   out  keystream word, bit 0 = earliest step
//   ks_valid  out  ks_data valid
//   ks_ready  in   consumer accepts ks_data
//   ks_count  out  words accepted since the last start (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset; no output, waits for start
// INIT  | warm-up; W steps per cycle, keystream discarded
// RUN   | ks_valid high; state advances W steps per accepted word
// ---------------------------------------------------------------------------
module trivium_ks_gen #(
    parameter int W           = 8,
    parameter int INIT_ROUNDS = 1152,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [79:0]      key,
    input  logic [79:0]      iv,
    output logic             busy,
    output logic [W-1:0]     ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [CNT_W-1:0] ks_count
);

    // Step counter only needs to reach INIT_ROUNDS; keep it at least 1 bit
    // wide so the zero-warm-up configuration still elaborates.
    localparam int CW     = (INIT_ROUNDS > 0) ? $clog2(INIT_ROUNDS + 1) : 1;
    localparam int LAST_I = (INIT_ROUNDS >= W) ? (INIT_ROUNDS - W) : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam logic [CW-1:0] INCR = CW'(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [287:0]     state_q, state_d;    // bit i holds s(i+1)
    logic [CW-1:0]    step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [287:0]     load_vec;
    logic [287:0]     st_walk;
    logic [W-1:0]     z_word;
    logic             t1, t2, t3;

    // s1..s80 = key, s94..s173 = iv, s286..s288 = 1, everything else 0.
    assign load_vec = {3'b111, 108'd0, 4'd0, iv, 13'd0, key};

    // W Trivium steps unrolled; step j sees the state after j steps and
    // produces keystream bit j.
    always_comb begin
        st_walk = state_q;
        z_word  = '0;
        t1      = 1'b0;
        t2      = 1'b0;
        t3      = 1'b0;
        for (int j = 0; j < W; j++) begin
            t1 = st_walk[65]  ^ st_walk[92];
            t2 = st_walk[161] ^ st_walk[176];
            t3 = st_walk[242] ^ st_walk[287];
            z_word[j] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (st_walk[90]  & st_walk[91])  ^ st_walk[170];
            t2 = t2 ^ (st_walk[174] & st_walk[175]) ^ st_walk[263];
            t3 = t3 ^ (st_walk[285] & st_walk[286]) ^ st_walk[68];
            // Each register shifts toward its high end; feedback enters at
            // s1, s94 and s178.
            st_walk = {st_walk[286:177], t2, st_walk[175:93], t1,
                       st_walk[91:0], t3};
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        count_d    = count_q;

        // start wins over everything, including a same-cycle handshake.
        if (start) begin
            state_d    = load_vec;
            step_cnt_d = '0;
            count_d    = '0;
            fsm_d      = (INIT_ROUNDS == 0) ? RUN : INIT;
        end else begin
            case (fsm_q)
                INIT: begin
                    state_d    = st_walk;
                    step_cnt_d = step_cnt_q + INCR;
                    if (step_cnt_q == LAST) begin
                        fsm_d = RUN;
                    end
                end
                RUN: begin
                    if (ks_ready) begin
                        state_d = st_walk;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            step_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        busy     = 1'b0;
        ks_valid = 1'b0;
        ks_data  = '0;
        case (fsm_q)
            INIT: busy = 1'b1;
            RUN: begin
                ks_valid = 1'b1;
                ks_data  = z_word;
            end
            default: ;
        endcase
    end

    assign ks_count = count_q;

endmodule

// File: tb/tb_trivium_ks_gen.sv
module tb_trivium_ks_gen;

    localparam logic [79:0] KA  = 80'h0F1E_2D3C_4B5A_6978_8796;
    localparam logic [79:0] IVA = 80'hA5A5_5A5A_0000_FFFF_1234;
    localparam logic [79:0] KB  = 80'hFEDC_BA98_7654_3210_0123;
    localparam logic [79:0] IVB = 80'h0000_0000_0000_0000_0001;

    logic        clk;
    logic        rst_b;
    logic [79:0] key, iv;

    logic        start8, ready8, busy8, valid8;
    logic [7:0]  data8;
    logic [31:0] cnt8;

    logic        start64, ready64, busy64, valid64;
    logic [63:0] data64;
    logic [31:0] cnt64;

    logic        start1, ready1, busy1, valid1;
    logic [0:0]  data1;
    logic [31:0] cnt1;

    logic        startz, readyz, busyz, validz;
    logic [7:0]  dataz;
    logic [3:0]  cntz;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2047:0] ref_a, ref_b, ref_z;

    trivium_ks_gen #(.W(8), .INIT_ROUNDS(1152), .CNT_W(32)) u8 (
        .clk(clk), .reset(rst_b), .start(start8), .key(key), .iv(iv),
        .busy(busy8), .ks_data(data8), .ks_valid(valid8),
        .ks_ready(ready8), .ks_count(cnt8));

    trivium_ks_gen #(.W(64), .INIT_ROUNDS(1152), .CNT_W(32)) u64 (
        .clk(clk), .reset(rst_b), .start(start64), .key(key), .iv(iv),
        .busy(busy64), .ks_data(data64), .ks_valid(valid64),
        .ks_ready(ready64), .ks_count(cnt64));

    trivium_ks_gen #(.W(1), .INIT_ROUNDS(1152), .CNT_W(32)) u1 (
        .clk(clk), .reset(rst_b), .start(start1), .key(key), .iv(iv),
        .busy(busy1), .ks_data(data1), .ks_valid(valid1),
        .ks_ready(ready1), .ks_count(cnt1));

    trivium_ks_gen #(.W(8), .INIT_ROUNDS(0), .CNT_W(4)) uz (
        .clk(clk), .reset(rst_b), .start(startz), .key(key), .iv(iv),
        .busy(busyz), .ks_data(dataz), .ks_valid(validz),
        .ks_ready(readyz), .ks_count(cntz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: s[1..288] indexed as in the algorithm description.
    task automatic model_run(input logic [79:0] k, input logic [79:0] v,
                             input int rounds, output logic [2047:0] out);
        logic [1:288] s;
        logic t1, t2, t3, z;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i + 1]  = k[i];
            s[94 + i] = v[i];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        out = '0;
        for (int n = 0; n < rounds + 2048; n++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            s[2:93]    = s[1:92];
            s[1]       = t3;
            s[95:177]  = s[94:176];
            s[94]      = t1;
            s[179:288] = s[178:287];
            s[178]     = t2;
            if (n >= rounds) out[n - rounds] = z;
        end
    endtask

    task automatic pulse_start8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Counts edges after the start edge until ks_valid of the W=8 unit rises.
    task automatic wait_run8(input int limit, output int edges);
        edges = 0;
        while (!valid8 && edges < limit) begin
            @(negedge clk);
            edges++;
        end
    endtask

    initial begin
        int          e;
        int          n;
        int          first8, first64, first1;
        int          n8, n64, n1;
        logic        prev_stall;
        logic [7:0]  held;
        logic [511:0] b8, b64, b1;
        logic [7:0]  zhand [0:7];

        zhand[0] = 8'h07;
        for (int i = 1; i < 8; i++) zhand[i] = 8'h00;

        model_run(KA, IVA, 1152, ref_a);
        model_run(KB, IVB, 1152, ref_b);
        model_run(80'd0, 80'd0, 0, ref_z);

        rst_b = 1'b0;
        key = '0; iv = '0;
        start8 = 0; start64 = 0; start1 = 0; startz = 0;
        ready8 = 0; ready64 = 0; ready1 = 0; readyz = 0;
        repeat (3) @(negedge clk);

        chk("rst_busy",  64'(busy8),  64'd0);
        chk("rst_valid", 64'(valid8), 64'd0);
        chk("rst_data",  64'(data8),  64'd0);
        chk("rst_count", 64'(cnt8),   64'd0);
        chk("rst_z_valid", 64'(validz), 64'd0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valid", 64'(valid8), 64'd0);

        // Zero warm-up, all-zero key/iv, counter wrap at 16.
        key = '0; iv = '0;
        startz = 1'b1; readyz = 1'b1;
        @(negedge clk);
        startz = 1'b0;
        chk("zinit_busy", 64'(busyz), 64'd0);
        for (int k = 0; k < 17; k++) begin
            chk("zinit_valid", 64'(validz), 64'd1);
            chk("zinit_count", 64'(cntz), 64'(k % 16));
            chk("zinit_model", 64'(dataz), 64'(ref_z[8*k +: 8]));
            if (k < 8) chk("zinit_hand", 64'(dataz), 64'(zhand[k]));
            @(negedge clk);
        end
        readyz = 1'b0;
        chk("zinit_wrap", 64'(cntz), 64'd1);
        held = dataz;
        repeat (2) @(negedge clk);
        chk("zinit_hold", 64'(dataz), 64'(held));
        chk("zinit_hold_model", 64'(dataz), 64'(ref_z[8*17 +: 8]));

        // Width equivalence with key/iv changed right after the start edge.
        ready8 = 1; ready64 = 1; ready1 = 1;
        key = KA; iv = IVA;
        start8 = 1; start64 = 1; start1 = 1;
        @(negedge clk);
        start8 = 0; start64 = 0; start1 = 0;
        key = KB; iv = IVB;
        chk("weq_busy8",  64'(busy8),  64'd1);
        chk("weq_busy64", 64'(busy64), 64'd1);
        chk("weq_busy1",  64'(busy1),  64'd1);
        first8 = -1; first64 = -1; first1 = -1;
        n8 = 0; n64 = 0; n1 = 0;
        b8 = '0; b64 = '0; b1 = '0;
        for (int c = 0; c < 2000; c++) begin
            if ((n8 == 64 && !ready8) && (n64 == 8 && !ready64) &&
                (n1 == 512 && !ready1)) break;
            if (c == 143) chk("weq_busy8_last", 64'(busy8), 64'd1);
            if (c == 144) chk("weq_busy8_done", 64'(busy8), 64'd0);
            if (valid8  && first8  < 0) first8  = c;
            if (valid64 && first64 < 0) first64 = c;
            if (valid1  && first1  < 0) first1  = c;
            if (n8 < 64) begin
                if (valid8) begin b8[8*n8 +: 8] = data8; n8++; end
            end else ready8 = 1'b0;
            if (n64 < 8) begin
                if (valid64) begin b64[64*n64 +: 64] = data64; n64++; end
            end else ready64 = 1'b0;
            if (n1 < 512) begin
                if (valid1) begin b1[n1] = data1[0]; n1++; end
            end else ready1 = 1'b0;
            @(negedge clk);
        end
        chk("weq_first8",  64'(first8),  64'd144);
        chk("weq_first64", 64'(first64), 64'd18);
        chk("weq_first1",  64'(first1),  64'd1152);
        chk("weq_cnt8",  64'(cnt8),  64'd64);
        chk("weq_cnt64", 64'(cnt64), 64'd8);
        chk("weq_cnt1",  64'(cnt1),  64'd512);
        for (int i = 0; i < 8; i++) begin
            chk("weq_w8",  b8[64*i +: 64],  ref_a[64*i +: 64]);
            chk("weq_w64", b64[64*i +: 64], ref_a[64*i +: 64]);
            chk("weq_w1",  b1[64*i +: 64],  ref_a[64*i +: 64]);
        end

        // Backpressure: random ready over 200 words.
        key = KA; iv = IVA; ready8 = 0;
        pulse_start8();
        wait_run8(300, e);
        chk("bp_init_len", 64'(e), 64'd144);
        n = 0;
        prev_stall = 1'b0;
        held = '0;
        for (int c = 0; c < 2000 && n < 200; c++) begin
            chk("bp_valid", 64'(valid8), 64'd1);
            chk("bp_data",  64'(data8),  64'(ref_a[8*n +: 8]));
            chk("bp_count", 64'(cnt8),   64'(n));
            if (prev_stall) chk("bp_hold", 64'(data8), 64'(held));
            ready8 = 1'($urandom_range(0, 1));
            prev_stall = !ready8;
            held = data8;
            if (ready8) n++;
            @(negedge clk);
        end
        ready8 = 1'b0;
        chk("bp_final_count", 64'(cnt8), 64'd200);

        // Restart during warm-up with a new key.
        key = KA; iv = IVA;
        pulse_start8();
        repeat (49) @(negedge clk);
        chk("rs_busy_before", 64'(busy8), 64'd1);
        key = KB; iv = IVB;
        pulse_start8();
        key = KA; iv = IVA;
        wait_run8(300, e);
        chk("rs_init_len", 64'(e), 64'd144);
        chk("rs_count0", 64'(cnt8), 64'd0);
        ready8 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("rs_keyb", 64'(data8), 64'(ref_b[8*k +: 8]));
            @(negedge clk);
        end
        ready8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rs_stall_data",  64'(data8), 64'(ref_b[48 +: 8]));
        chk("rs_stall_count", 64'(cnt8),  64'd6);

        // Restart mid-stall with a same-cycle handshake: start wins.
        key = KB; iv = IVB;
        ready8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; ready8 = 1'b0;
        chk("rs2_busy",  64'(busy8),  64'd1);
        chk("rs2_valid", 64'(valid8), 64'd0);
        chk("rs2_count", 64'(cnt8),   64'd0);
        wait_run8(300, e);
        chk("rs2_init_len", 64'(e), 64'd144);
        chk("rs2_count0", 64'(cnt8), 64'd0);
        ready8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rs2_keyb", 64'(data8), 64'(ref_b[8*k +: 8]));
            @(negedge clk);
        end
        chk("rs2_count4", 64'(cnt8), 64'd4);

        // Reset while running; reset beats a concurrent start.
        rst_b = 1'b0; start8 = 1'b1;
        @(negedge clk);
        chk("mrst_busy",  64'(busy8),  64'd0);
        chk("mrst_valid", 64'(valid8), 64'd0);
        chk("mrst_data",  64'(data8),  64'd0);
        chk("mrst_count", 64'(cnt8),   64'd0);
        chk("mrst_z_count", 64'(cntz), 64'd0);
        rst_b = 1'b1; start8 = 1'b0; ready8 = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_idle_valid", 64'(valid8), 64'd0);
        chk("mrst_idle_busy",  64'(busy8),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
